// File: rtl/report_collector_c2.sv
// Report collector, cluster 2: samples per-symbol report strobes, encodes each
// set strobe into a {stamp, id} record and queues the records in a FWFT FIFO.
module report_collector_c2 #(
    parameter int NUM_REPORTS = 40,
    parameter int ID_W        = 6,
    parameter int STAMP_W     = 16,
    parameter int FIFO_DEPTH  = 16,
    parameter int CNT_W       = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     run,
    input  logic [NUM_REPORTS-1:0]   report_vec,
    input  logic                     flush,
    output logic                     rd_valid,
    input  logic                     rd_ready,
    output logic [STAMP_W+ID_W-1:0]  rd_data,
    output logic                     pending,
    output logic                     overflow,
    output logic [CNT_W-1:0]         drop_count
);
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int REC_W = STAMP_W + ID_W;

    logic [STAMP_W-1:0]     stamp;
    logic [STAMP_W-1:0]     cap_stamp;
    logic [NUM_REPORTS-1:0] cap_vec;
    logic [NUM_REPORTS-1:0] cap_rest;
    logic [ID_W-1:0]        low_id;
    logic [REC_W-1:0]       mem [FIFO_DEPTH];
    logic [AW-1:0]          wr_ptr;
    logic [AW-1:0]          rd_ptr;
    logic [AW:0]            count;
    logic                   full, pop, push, cap_free, hit, capture, drop;

    assign pending  = |cap_vec;
    assign full     = (count == (AW+1)'(FIFO_DEPTH));
    assign rd_valid = (count != '0);
    // Head is forced to zero when empty so the port reads 0 out of reset.
    assign rd_data  = rd_valid ? mem[rd_ptr] : '0;
    assign pop      = rd_valid & rd_ready;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign push     = pending & (~full | pop);
    // Capture register with its lowest set bit removed.
    assign cap_rest = cap_vec & (cap_vec - NUM_REPORTS'(1));
    // Free if empty, or if the final bit is leaving this cycle.
    assign cap_free = ~pending | (push & ~(|cap_rest));
    assign hit      = run & (|report_vec);
    assign capture  = hit & cap_free;
    assign drop     = hit & ~cap_free;

    // Lowest-set-bit encoder; scanning downward lets the lowest index win.
    always_comb begin
        low_id = '0;
        for (int i = NUM_REPORTS - 1; i >= 0; i--) begin
            if (cap_vec[i]) low_id = ID_W'(i);
        end
    end

    // Stamp, capture register, FIFO pointers and drop bookkeeping; flush wins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stamp      <= '0;
            cap_stamp  <= '0;
            cap_vec    <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (flush) begin
            stamp      <= '0;
            cap_stamp  <= '0;
            cap_vec    <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow   <= 1'b0;
            drop_count <= '0;
        end else begin
            if (run) stamp <= stamp + STAMP_W'(1);
            if (capture) begin
                cap_vec   <= report_vec;
                cap_stamp <= stamp;
            end else if (push) begin
                cap_vec   <= cap_rest;
            end
            if (drop) begin
                overflow <= 1'b1;
                if (~&drop_count) drop_count <= drop_count + CNT_W'(1);
            end
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Record storage; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= {cap_stamp, low_id};
    end
endmodule

// File: tb/tb_report_collector_c2.sv
// Directed bench for report_collector_c2 with an expected-record scoreboard.
module tb_report_collector_c2;
    localparam int NR = 40;
    localparam int RW = 22;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          run = 1'b0;
    logic [NR-1:0] report_vec = '0;
    logic          flush = 1'b0;
    logic          rd_valid;
    logic          rd_ready = 1'b0;
    logic [RW-1:0] rd_data;
    logic          pending;
    logic          overflow;
    logic [15:0]   drop_count;

    int            checks = 0;
    int            failures = 0;
    logic [15:0]   tb_stamp = '0;
    logic [RW-1:0] exp_q[$];

    report_collector_c2 dut (
        .clk(clk), .reset_n(reset_n), .run(run), .report_vec(report_vec),
        .flush(flush), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .rd_data(rd_data), .pending(pending), .overflow(overflow),
        .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NR-1:0] bitv(input int b);
        logic [NR-1:0] one;
        one = 1;
        return one << b;
    endfunction

    // Queue one expected record per set bit, lowest index first.
    task automatic exp_push(input logic [15:0] st, input logic [NR-1:0] v);
        for (int i = 0; i < NR; i++)
            if (v[i]) exp_q.push_back({st, 6'(i)});
    endtask

    // One clock with the given inputs; tracks the expected stamp.
    task automatic cyc(input logic r, input logic [NR-1:0] v, input logic f);
        run = r; report_vec = v; flush = f;
        @(posedge clk);
        #1;
        if (f) tb_stamp = '0;
        else if (r) tb_stamp = tb_stamp + 16'd1;
        run = 1'b0; report_vec = '0; flush = 1'b0;
    endtask

    // Accepted sample: expected records queued at the pre-increment stamp.
    task automatic sample(input logic [NR-1:0] v);
        exp_push(tb_stamp, v);
        cyc(1'b1, v, 1'b0);
    endtask

    task automatic drain(input string tag, input int max);
        int n = 0;
        while ((exp_q.size() != 0 || pending || rd_valid) && n < max) begin
            cyc(1'b0, '0, 1'b0);
            n++;
        end
        chk(tag, 64'(n < max), 64'd1);
    endtask

    // Scoreboard: every accepted head must match the oldest expected record.
    always @(negedge clk) begin
        if (reset_n && rd_valid && rd_ready) begin
            if (exp_q.size() == 0) chk("unexpected_record", 64'(rd_data), 64'hDEAD);
            else chk("record", 64'(rd_data), 64'(exp_q.pop_front()));
        end
    end

    initial begin
        // Reset state
        #2;
        chk("rst_valid", 64'(rd_valid), 0);
        chk("rst_data", 64'(rd_data), 0);
        chk("rst_pending", 64'(pending), 0);
        chk("rst_ovf", 64'(overflow), 0);
        chk("rst_drops", 64'(drop_count), 0);
        @(posedge clk); #1;
        reset_n = 1'b1;

        // Single strobe at stamp 0, head held with rd_ready low
        sample(bitv(13));
        chk("s1_pending", 64'(pending), 1);
        chk("s1_valid_early", 64'(rd_valid), 0);
        cyc(1'b0, '0, 1'b0);
        chk("s1_valid", 64'(rd_valid), 1);
        chk("s1_pending_fall", 64'(pending), 0);
        chk("s1_data", 64'(rd_data), {16'h0000, 6'd13});
        cyc(1'b0, '0, 1'b0);
        chk("s1_data_stable", 64'(rd_data), {16'h0000, 6'd13});
        rd_ready = 1'b1;
        drain("s1_drain", 10);

        // Multi-bit ordering at stamp 5
        while (tb_stamp != 16'd5) cyc(1'b1, '0, 1'b0);
        sample(bitv(2) | bitv(7) | bitv(39));
        cyc(1'b0, '0, 1'b0);
        cyc(1'b0, '0, 1'b0);
        chk("m_pending_2", 64'(pending), 1);
        cyc(1'b0, '0, 1'b0);
        chk("m_pending_3", 64'(pending), 0);
        drain("m_drain", 10);

        // Drop: second sample arrives while four bits are draining
        sample(bitv(0) | bitv(1) | bitv(2) | bitv(3));
        cyc(1'b1, bitv(8), 1'b0);
        chk("d_ovf", 64'(overflow), 1);
        chk("d_drops", 64'(drop_count), 1);
        drain("d_drain", 10);
        sample(bitv(20));
        drain("d_after", 10);
        // Capture on the edge the last bit drains: no drop
        sample(bitv(5));
        sample(bitv(6));
        chk("b2b_drops", 64'(drop_count), 1);
        drain("b2b_drain", 10);

        // Backpressure: 20 samples into a 16-entry FIFO
        rd_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (i < 17) sample(bitv((i * 3) % NR));
            else cyc(1'b1, bitv((i * 3) % NR), 1'b0);
            cyc(1'b1, '0, 1'b0);
        end
        chk("bp_drops", 64'(drop_count), 4);
        chk("bp_pending", 64'(pending), 1);
        chk("bp_valid", 64'(rd_valid), 1);
        rd_ready = 1'b1;
        drain("bp_drain", 40);

        // Flush with a simultaneous capture: flush wins
        rd_ready = 1'b0;
        sample(bitv(3) | bitv(4));
        cyc(1'b1, bitv(9), 1'b0);
        chk("f_ovf_pre", 64'(overflow), 1);
        cyc(1'b1, bitv(7), 1'b1);
        exp_q.delete();
        chk("f_valid", 64'(rd_valid), 0);
        chk("f_pending", 64'(pending), 0);
        chk("f_ovf", 64'(overflow), 0);
        chk("f_drops", 64'(drop_count), 0);
        rd_ready = 1'b1;
        sample(bitv(30));
        drain("f_restart", 10);

        // Stamp wrap 0xFFFF -> 0x0000
        while (tb_stamp != 16'hFFFF) cyc(1'b1, '0, 1'b0);
        sample(bitv(1));
        sample(bitv(2));
        chk("w_stamp0", 64'(tb_stamp), 1);
        drain("w_drain", 10);

        // Async reset mid-drain: nothing further may emerge
        cyc(1'b1, bitv(10) | bitv(11) | bitv(12) | bitv(13), 1'b0);
        cyc(1'b0, '0, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        chk("ar_valid", 64'(rd_valid), 0);
        chk("ar_data", 64'(rd_data), 0);
        chk("ar_pending", 64'(pending), 0);
        chk("ar_ovf", 64'(overflow), 0);
        chk("ar_drops", 64'(drop_count), 0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        tb_stamp = '0;
        repeat (8) cyc(1'b0, '0, 1'b0);
        chk("ar_quiet", 64'(rd_valid), 0);
        chk("q_empty", 64'(exp_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/report_collector_c2.md
Name: report_collector_c2

Overview:
- Consumer end of the cluster-2 automata stage.
- Samples the 40 per-symbol report strobes produced while symbols stream through the automata.
- Encodes each asserted strobe into a (symbol stamp, report ID) record and buffers the records in a first-word-fall-through FIFO.
- Monitor software and downstream logic drain the FIFO over a valid/ready read port.

Parameters:
NUM_REPORTS, 40, width of report vector (ltl0..ltl9 x 4 strobes, ordered ltl0c2 bit0..3, ltl1c2 bit4..7, ...)
ID_W, 6, report ID width; ceil(log2(NUM_REPORTS))
STAMP_W, 16, symbol stamp width
FIFO_DEPTH, 16, record FIFO entries (power of 2)
CNT_W, 16, drop counter width

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
run  in  1  symbol-valid qualifier, same cycle as report_vec
report_vec  in  NUM_REPORTS  report strobes for current symbol
flush  in  1  synchronous clear of stamp, pending, FIFO, drop state
rd_valid  out  1  FIFO head valid
rd_ready  in  1  consumer accepts head
rd_data  out  STAMP_W+ID_W  {stamp, id} of head record
pending  out  1  capture register holds undrained bits
overflow  out  1  sticky: at least one sample dropped
drop_count  out  CNT_W  dropped samples, saturating

Behaviour:
- Reset values: all outputs 0; stamp=0; capture register empty; FIFO empty. Asynchronous reset takes effect immediately, including mid-drain.
- Stamp counter:
  - Increments on every clk edge with run=1; wraps 2^STAMP_W-1 -> 0.
  - The stamp recorded for a sample is the counter value before that increment.
- Capture:
  - Occurs on an edge with run=1 and report_vec!=0.
  - Capture register free (pending=0, or the last remaining bit is being pushed this cycle): loads report_vec and stamp; pending=1 next cycle.
  - Capture register busy: sample dropped, overflow<=1, drop_count increments (saturates at all-ones).
  - run=0, or report_vec==0: no capture, no drop.
- Drain (one record per cycle):
  - When pending=1 and the FIFO can accept, push {stamp, lowest set bit index} and clear that bit.
  - pending falls on the edge that clears the last bit.
- FIFO:
  - First-word fall-through; rd_data is stable while rd_valid=1 and rd_ready=0.
  - Pop on rd_valid&rd_ready.
  - Push is permitted when not full, or when full with a pop in the same cycle.
  - Full without a pop: drain stalls and the capture register holds. Stalling never loses bits; only new samples arriving while pending=1 are dropped.
  - Empty with push and no pop: rd_valid rises next cycle.
- Latency: sample at edge N -> first record pushed at edge N+1 -> rd_valid=1 in the cycle after edge N+1. A k-bit sample completes draining k edges after capture, absent stalls.
- Flush:
  - Takes effect at the next edge and overrides a capture in the same cycle.
  - Clears stamp, capture register, FIFO, overflow and drop_count.
  - rd_valid=0 the cycle after.
- Simultaneous events:
  - Capture while the last bit drains: both happen, no drop.
  - Pop and push on a full FIFO: occupancy unchanged.
  - Pop and push on an empty FIFO: the push is not bypassed (no bypass path); rd_valid rises next cycle.

Test Plan:
- Single strobe: reset, run=1, report_vec bit 13 at stamp 0 -> one record {0x0000, 13}, rd_valid one cycle after push; pending 1 for one cycle.
- Multi-bit ordering: report_vec bits {2,7,39} at stamp 5, rd_ready=1 -> records {5,2},{5,7},{5,39} on consecutive cycles; pending drops after third push.
- Drop: bits {0..3} at stamp 0, then run=1 with bit 8 on the next cycle -> second sample dropped, overflow=1, drop_count=1; next sample after drain is accepted normally.
- Backpressure: rd_ready=0, 20 single-bit samples spaced 2 cycles apart -> FIFO holds 16 records, capture register stalls holding one bit; later samples counted in drop_count. Raise rd_ready -> records emerge in order with correct stamps.
- Wrap and flush: preload stamp near 0xFFFF via 65535 run cycles with report_vec=0; report at stamp 0xFFFF then 0x0000 -> stamps wrap correctly. Assert flush -> rd_valid=0, overflow=0, stamp restarts at 0.
- Async reset mid-drain: reset_n low during multi-bit drain -> all outputs 0 immediately, no record emitted after release.
